// File: rtl/pdm2pcm_clock_sequencer.sv
// PDM2PCM front-end clock sequencer.
// Generates the PDM microphone clock from a programmable divisor and discards a
// fixed number of PDM periods after enable so the microphones can settle. It then
// samples the shared PDM data line once per clock phase. The end of the high phase
// carries LEFT data and the end of the low phase carries RIGHT data. Each bit is
// steered to its decimator path, gated by channel mode, buffer enables and
// buffer-full back-pressure.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | interface disabled, pdm_clk low, counter cleared
// WARMUP | pdm_clk running, toggle events counted, no samples issued
// RUN    | pdm_clk running, one capture per toggle event

module pdm2pcm_clock_sequencer #(
    parameter int DIV_WIDTH      = 7,
    parameter int SYNC_STAGES    = 2,
    parameter int WARMUP_PERIODS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 dual_channel_i,
    input  logic                 channel_i,
    input  logic [1:0]           buffer_en_i,
    input  logic [1:0]           buffer_full_i,
    input  logic                 pdm_data_i,
    output logic                 pdm_clk_o,
    output logic [1:0]           sample_valid_o,
    output logic                 sample_data_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int RISE_W = (WARMUP_PERIODS > 1) ? $clog2(WARMUP_PERIODS) : 1;
    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(WARMUP_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [DIV_WIDTH-1:0]   cnt, cnt_next;
    logic [DIV_WIDTH-1:0]   div_q, div_next;
    logic                   pclk, pclk_next;
    logic [RISE_W-1:0]      rise_cnt, rise_next;
    logic [1:0]             valid_next;
    logic                   data_next;
    logic                   overrun_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   toggle;
    logic                   slot;
    logic                   slot_active;

    // Half-period boundary: the counter has reached the latched divisor.
    assign toggle = (cnt == div_q);

    // Falling toggle closes the high phase (LEFT = 0); rising toggle closes the low phase (RIGHT = 1).
    assign slot = ~pclk;

    assign slot_active = dual_channel_i | (channel_i == slot);

    // Metastability synchronizer for the asynchronous PDM data line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pdm_data_i};
        end
    end

    // Next-state, divider and capture decisions.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        div_next     = div_q;
        pclk_next    = pclk;
        rise_next    = rise_cnt;
        valid_next   = 2'b00;
        data_next    = sample_data_o;
        overrun_next = 1'b0;

        case (state)
            IDLE: begin
                cnt_next  = '0;
                pclk_next = 1'b0;
                if (enable_i) begin
                    state_next = WARMUP;
                    div_next   = divisor_i;
                    rise_next  = '0;
                end
            end

            WARMUP, RUN: begin
                if (!enable_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    pclk_next  = 1'b0;
                end else if (toggle) begin
                    pclk_next = ~pclk;
                    cnt_next  = '0;
                    // Divisor changes only take effect at a half-period boundary.
                    div_next  = divisor_i;
                    if (state == WARMUP) begin
                        if (!pclk) begin
                            rise_next = rise_cnt + 1'b1;
                            if (rise_cnt == RISE_LAST) begin
                                state_next = RUN;
                            end
                        end
                    end else begin
                        data_next = sync[SYNC_STAGES-1];
                        if (slot_active && buffer_en_i[slot]) begin
                            if (buffer_full_i[slot]) begin
                                overrun_next = 1'b1;
                            end else begin
                                valid_next[slot] = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                pclk_next  = 1'b0;
            end
        endcase
    end

    // State, divider and registered output updates.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            cnt            <= '0;
            div_q          <= '0;
            pclk           <= 1'b0;
            rise_cnt       <= '0;
            sample_valid_o <= 2'b00;
            sample_data_o  <= 1'b0;
            overrun_o      <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            div_q          <= div_next;
            pclk           <= pclk_next;
            rise_cnt       <= rise_next;
            sample_valid_o <= valid_next;
            sample_data_o  <= data_next;
            overrun_o      <= overrun_next;
            busy_o         <= (state_next != IDLE);
        end
    end

    assign pdm_clk_o = pclk;

endmodule

// File: tb/tb_pdm2pcm_clock_sequencer.sv
// Directed bench for pdm2pcm_clock_sequencer: divider timing, warm-up, channel
// steering, back-pressure, enable drop/re-enable, divisor change and async reset.

module tb_pdm2pcm_clock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] divisor = 7'd0;
    logic       dual = 1'b0;
    logic       channel = 1'b0;
    logic [1:0] buffer_en = 2'b00;
    logic [1:0] buffer_full = 2'b00;
    logic       pdm_data = 1'b0;
    logic       pdm_clk;
    logic [1:0] sample_valid;
    logic       sample_data;
    logic       overrun;
    logic       busy;

    int   tests = 0;
    int   fails = 0;
    logic follow = 1'b0;
    logic [1:0] seen = 2'b00;
    logic seen_ovr = 1'b0;
    logic seen_both = 1'b0;

    pdm2pcm_clock_sequencer #(
        .DIV_WIDTH(7),
        .SYNC_STAGES(2),
        .WARMUP_PERIODS(4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .divisor_i      (divisor),
        .dual_channel_i (dual),
        .channel_i      (channel),
        .buffer_en_i    (buffer_en),
        .buffer_full_i  (buffer_full),
        .pdm_data_i     (pdm_data),
        .pdm_clk_o      (pdm_clk),
        .sample_valid_o (sample_valid),
        .sample_data_o  (sample_data),
        .overrun_o      (overrun),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            seen      = seen | sample_valid;
            seen_ovr  = seen_ovr | overrun;
            seen_both = seen_both | (&sample_valid);
            if (follow) pdm_data = pdm_clk;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("idle_busy", busy, 0);

        // Test 1/2: divisor 3, dual, data follows pdm_clk
        divisor   = 7'd3;
        dual      = 1'b1;
        buffer_en = 2'b11;
        follow    = 1'b1;
        enable    = 1'b1;
        seen      = 2'b00;
        cyc(1);                                   // E0
        check("e0_busy", busy, 1);
        check("e0_pdm_clk", pdm_clk, 0);
        cyc(3);                                   // E3
        check("e3_pdm_clk", pdm_clk, 0);
        cyc(1);                                   // E4
        check("e4_pdm_clk_rise", pdm_clk, 1);
        cyc(3);                                   // E7
        check("e7_pdm_clk_high", pdm_clk, 1);
        cyc(1);                                   // E8
        check("e8_pdm_clk_fall", pdm_clk, 0);
        cyc(20);                                  // E28
        check("e28_pdm_clk_rise4", pdm_clk, 1);
        check("warmup_no_strobe", seen, 0);
        cyc(3);                                   // E31
        check("e31_valid", sample_valid, 0);
        cyc(1);                                   // E32
        check("e32_valid_left", sample_valid, 2'b01);
        check("e32_data_left", sample_data, 1);
        check("e32_pdm_clk", pdm_clk, 0);
        cyc(1);                                   // E33
        check("e33_valid_held1", sample_valid, 0);
        cyc(3);                                   // E36
        check("e36_valid_right", sample_valid, 2'b10);
        check("e36_data_right", sample_data, 0);
        check("e36_pdm_clk", pdm_clk, 1);
        cyc(4);                                   // E40
        check("e40_valid_left", sample_valid, 2'b01);
        check("e40_data_left", sample_data, 1);
        cyc(4);                                   // E44
        check("e44_valid_right", sample_valid, 2'b10);
        check("e44_data_right", sample_data, 0);

        // Test 3: single mode, RIGHT only
        dual    = 1'b0;
        channel = 1'b1;
        seen    = 2'b00;
        cyc(16);                                  // E60
        check("single_right_seen", seen, 2'b10);
        check("e60_valid_right", sample_valid, 2'b10);

        // Test 4: LEFT full -> overrun at LEFT slots
        dual        = 1'b1;
        buffer_full = 2'b01;
        cyc(4);                                   // E64
        check("e64_overrun", overrun, 1);
        check("e64_no_left", sample_valid, 0);
        cyc(1);                                   // E65
        check("e65_overrun_pulse", overrun, 0);
        cyc(3);                                   // E68
        check("e68_valid_right", sample_valid, 2'b10);
        check("e68_overrun", overrun, 0);
        buffer_en = 2'b10;
        seen      = 2'b00;
        seen_ovr  = 1'b0;
        cyc(4);                                   // E72
        check("e72_disabled_overrun", overrun, 0);
        check("e72_disabled_valid", sample_valid, 0);
        cyc(8);                                   // E80
        check("disabled_no_overrun", seen_ovr, 0);
        check("disabled_right_seen", seen, 2'b10);
        buffer_en   = 2'b11;
        buffer_full = 2'b00;

        // Test 5: enable drop mid high phase, then re-enable
        cyc(5);                                   // E85
        check("e85_pdm_clk_high", pdm_clk, 1);
        enable = 1'b0;
        cyc(1);                                   // E86
        check("drop_pdm_clk", pdm_clk, 0);
        check("drop_busy", busy, 0);
        check("drop_valid", sample_valid, 0);
        seen = 2'b00;
        cyc(20);
        check("idle_no_strobe", seen, 0);
        check("idle_pdm_clk", pdm_clk, 0);
        enable = 1'b1;
        cyc(1);                                   // F0
        check("f0_busy", busy, 1);
        seen = 2'b00;
        cyc(27);                                  // F27
        check("f27_pdm_clk", pdm_clk, 0);
        check("rewarm_no_strobe", seen, 0);
        cyc(1);                                   // F28
        check("f28_pdm_clk", pdm_clk, 1);
        check("f28_valid", sample_valid, 0);
        cyc(4);                                   // F32
        check("f32_valid_left", sample_valid, 2'b01);
        check("f32_data", sample_data, 1);
        cyc(3);                                   // F35 (toggle cycle)
        enable = 1'b0;
        cyc(1);                                   // F36
        check("f36_no_capture", sample_valid, 0);
        check("f36_pdm_clk", pdm_clk, 0);
        check("f36_busy", busy, 0);

        // Test 6: divisor 3 -> 0 mid half-period, then async reset mid-RUN
        cyc(3);
        follow   = 1'b0;
        pdm_data = 1'b1;
        divisor  = 7'd3;
        enable   = 1'b1;
        cyc(1);                                   // G0
        divisor = 7'd0;
        cyc(3);                                   // G3
        check("g3_pdm_clk", pdm_clk, 0);
        cyc(1);                                   // G4
        check("g4_pdm_clk", pdm_clk, 1);
        cyc(1);                                   // G5
        check("g5_pdm_clk", pdm_clk, 0);
        cyc(1);                                   // G6
        check("g6_pdm_clk", pdm_clk, 1);
        cyc(4);                                   // G10
        check("g10_pdm_clk", pdm_clk, 1);
        check("g10_valid", sample_valid, 0);
        cyc(1);                                   // G11
        check("g11_valid_left", sample_valid, 2'b01);
        check("g11_data", sample_data, 1);
        check("g11_pdm_clk", pdm_clk, 0);
        cyc(1);                                   // G12
        check("g12_valid_right", sample_valid, 2'b10);
        check("g12_pdm_clk", pdm_clk, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pdm_clk", pdm_clk, 0);
        check("arst_valid", sample_valid, 0);
        check("arst_data", sample_data, 0);
        check("arst_overrun", overrun, 0);
        check("arst_busy", busy, 0);
        check("never_both_valid", seen_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
